// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: decoded ID operands and pipeline controls in, stall/issue/occupancy out.
// stall_cnt_o exists only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int ADDR_W      = 5,
  parameter int NUM_ENTRIES = 2
);
  localparam int PCW = $clog2(NUM_ENTRIES + 1);

  logic              id_valid_i;
  logic [ADDR_W-1:0] id_rs1_addr_i;
  logic [ADDR_W-1:0] id_rs2_addr_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic [ADDR_W-1:0] id_rd_addr_i;
  logic              id_rd_wr_i;
  logic              id_load_i;
  logic              freeze_i;
  logic              flush_i;
  logic              stall_o;
  logic              issue_o;
  logic              full_o;
  logic [PCW-1:0]    pending_cnt_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]       stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_rd_wr_i, id_load_i, freeze_i, flush_i,
    input  stall_o, issue_o, full_o, pending_cnt_o, stall_cnt_o
  );
  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_rd_wr_i, id_load_i, freeze_i, flush_i,
    output stall_o, issue_o, full_o, pending_cnt_o, stall_cnt_o
  );
`else
  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_rd_wr_i, id_load_i, freeze_i, flush_i,
    input  stall_o, issue_o, full_o, pending_cnt_o
  );
  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_rd_wr_i, id_load_i, freeze_i, flush_i,
    output stall_o, issue_o, full_o, pending_cnt_o
  );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / multi-cycle hazard scoreboard: stall_o and issue_o are combinational from current entries; full/count are registered.
// freeze_i holds every entry; optional HAZARD_STATS_EN adds a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int ADDR_W      = 5,
  parameter int NUM_ENTRIES = 2,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  hazard_scoreboard_if.slave sb
);
  localparam int PCW = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]      rd_q  [NUM_ENTRIES];
  logic [ADDR_W-1:0]      rd_d  [NUM_ENTRIES];
  logic [CNT_W-1:0]       cnt_q [NUM_ENTRIES];
  logic [CNT_W-1:0]       cnt_d [NUM_ENTRIES];
  logic                   full_q;
  logic [PCW-1:0]         pend_q, pend_d;

  logic raw_hit, waw_hit, rd_match;
  logic live, stall, issue, alloc, found;

  always_comb begin
    raw_hit  = 1'b0;
    waw_hit  = 1'b0;
    rd_match = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (vld_q[i]) begin
        if (sb.id_rs1_used_i && sb.id_rs1_addr_i != '0 && sb.id_rs1_addr_i == rd_q[i]) raw_hit = 1'b1;
        if (sb.id_rs2_used_i && sb.id_rs2_addr_i != '0 && sb.id_rs2_addr_i == rd_q[i]) raw_hit = 1'b1;
        if (sb.id_rd_addr_i == rd_q[i]) begin
          rd_match = 1'b1;
          if (sb.id_rd_wr_i && sb.id_rd_addr_i != '0) waw_hit = 1'b1;
        end
      end
    end
  end

  assign live  = sb.id_valid_i && !sb.flush_i;
  assign stall = live && (raw_hit || waw_hit || (sb.id_load_i && full_q && !rd_match));
  assign issue = live && !stall && !sb.freeze_i;
  assign alloc = issue && sb.id_load_i && sb.id_rd_wr_i && (sb.id_rd_addr_i != '0);

  // Allocation searches the pre-edge valid map, so a retiring slot is never reused on the same edge.
  always_comb begin
    vld_d  = vld_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    found  = 1'b0;
    pend_d = '0;
    if (!sb.freeze_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (vld_q[i]) begin
          if (cnt_q[i] > CNT_W'(1)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end else begin
            vld_d[i] = 1'b0;
            cnt_d[i] = '0;
          end
        end
      end
      if (alloc) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (!found && !vld_q[i]) begin
            found    = 1'b1;
            vld_d[i] = 1'b1;
            rd_d[i]  = sb.id_rd_addr_i;
            cnt_d[i] = CNT_W'(LOAD_LAT);
          end
        end
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) pend_d = pend_d + PCW'(vld_d[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      full_q <= 1'b0;
      pend_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      full_q <= &vld_d;
      pend_q <= pend_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sb.stall_o       = stall;
  assign sb.issue_o       = issue;
  assign sb.full_o        = full_q;
  assign sb.pending_cnt_o = pend_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall && !sb.freeze_i && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sb.stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances against a pending-load list model.
module tb_hazard_scoreboard;
  localparam int NE = 2;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       frz;
    logic       fl;
  } in_t;

  logic clk;
  logic rst;
  in_t  cur_in [2];

  int n_cmp = 0;
  int n_bad = 0;

  // model: per instance, an ordered list of pending loads (rd, cycles left)
  logic [4:0] m_rd  [2][8];
  int         m_rem [2][8];
  int         m_n   [2];
  longint     m_sc  [2];

  hazard_scoreboard_if #(.ADDR_W(5), .NUM_ENTRIES(NE)) ifa ();
  hazard_scoreboard_if #(.ADDR_W(5), .NUM_ENTRIES(NE)) ifb ();

  hazard_scoreboard #(.ADDR_W(5), .NUM_ENTRIES(NE), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .sb(ifa)
  );
  hazard_scoreboard #(.ADDR_W(5), .NUM_ENTRIES(NE), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .sb(ifb)
  );

  assign ifa.id_valid_i    = cur_in[0].v;
  assign ifa.id_rs1_addr_i = cur_in[0].rs1;
  assign ifa.id_rs1_used_i = cur_in[0].u1;
  assign ifa.id_rs2_addr_i = cur_in[0].rs2;
  assign ifa.id_rs2_used_i = cur_in[0].u2;
  assign ifa.id_rd_addr_i  = cur_in[0].rd;
  assign ifa.id_rd_wr_i    = cur_in[0].wr;
  assign ifa.id_load_i     = cur_in[0].ld;
  assign ifa.freeze_i      = cur_in[0].frz;
  assign ifa.flush_i       = cur_in[0].fl;
  assign ifb.id_valid_i    = cur_in[1].v;
  assign ifb.id_rs1_addr_i = cur_in[1].rs1;
  assign ifb.id_rs1_used_i = cur_in[1].u1;
  assign ifb.id_rs2_addr_i = cur_in[1].rs2;
  assign ifb.id_rs2_used_i = cur_in[1].u2;
  assign ifb.id_rd_addr_i  = cur_in[1].rd;
  assign ifb.id_rd_wr_i    = cur_in[1].wr;
  assign ifb.id_load_i     = cur_in[1].ld;
  assign ifb.freeze_i      = cur_in[1].frz;
  assign ifb.flush_i       = cur_in[1].fl;

  logic   o_stall [2];
  logic   o_issue [2];
  logic   o_full  [2];
  longint o_pend  [2];
  longint o_scnt  [2];
  assign o_stall[0] = ifa.stall_o;
  assign o_stall[1] = ifb.stall_o;
  assign o_issue[0] = ifa.issue_o;
  assign o_issue[1] = ifb.issue_o;
  assign o_full[0]  = ifa.full_o;
  assign o_full[1]  = ifb.full_o;
  assign o_pend[0]  = longint'(ifa.pending_cnt_o);
  assign o_pend[1]  = longint'(ifb.pending_cnt_o);
`ifdef HAZARD_STATS_EN
  assign o_scnt[0]  = longint'(ifa.stall_cnt_o);
  assign o_scnt[1]  = longint'(ifb.stall_cnt_o);
`else
  assign o_scnt[0]  = 0;
  assign o_scnt[1]  = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_stall(input int d);
    logic raw, waw, match;
    in_t  x;
    x = cur_in[d];
    raw = 1'b0; waw = 1'b0; match = 1'b0;
    for (int k = 0; k < m_n[d]; k++) begin
      if (x.u1 && x.rs1 != 5'd0 && x.rs1 == m_rd[d][k]) raw = 1'b1;
      if (x.u2 && x.rs2 != 5'd0 && x.rs2 == m_rd[d][k]) raw = 1'b1;
      if (x.rd == m_rd[d][k]) match = 1'b1;
      if (x.wr && x.rd != 5'd0 && x.rd == m_rd[d][k]) waw = 1'b1;
    end
    return x.v && !x.fl && (raw || waw || (x.ld && m_n[d] == NE && !match));
  endfunction

  function automatic logic exp_issue(input int d);
    return cur_in[d].v && !cur_in[d].fl && !exp_stall(d) && !cur_in[d].frz;
  endfunction

  task automatic model_step(input int d);
    in_t x;
    logic st, is_;
    int pre, nn, lat;
    x   = cur_in[d];
    st  = exp_stall(d);
    is_ = exp_issue(d);
    lat = (d == 0) ? 1 : 3;
    if (!x.frz) begin
      if (st && m_sc[d] < 64'hFFFF_FFFF) m_sc[d]++;
      pre = m_n[d];
      nn  = 0;
      for (int k = 0; k < pre; k++) begin
        if (m_rem[d][k] > 1) begin
          m_rd[d][nn]  = m_rd[d][k];
          m_rem[d][nn] = m_rem[d][k] - 1;
          nn++;
        end
      end
      if (is_ && x.ld && x.wr && x.rd != 5'd0 && pre < NE) begin
        m_rd[d][nn]  = x.rd;
        m_rem[d][nn] = lat;
        nn++;
      end
      m_n[d] = nn;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_n[d]  = 0;
        m_sc[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("stall[%0d]", d), o_stall[d], exp_stall(d));
      check($sformatf("issue[%0d]", d), o_issue[d], exp_issue(d));
      check($sformatf("full[%0d]", d), o_full[d], (m_n[d] == NE) ? 1 : 0);
      check($sformatf("pend[%0d]", d), o_pend[d], m_n[d]);
`ifdef HAZARD_STATS_EN
      check($sformatf("stall_cnt[%0d]", d), o_scnt[d], m_sc[d]);
`endif
    end
  end

  function automatic in_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic wr, input logic ld);
    in_t x;
    x     = '0;
    x.v   = v;   x.rs1 = rs1; x.u1 = u1;
    x.rs2 = rs2; x.u2  = u2;  x.rd = rd;
    x.wr  = wr;  x.ld  = ld;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cur_in[0] = '0;
    cur_in[1] = '0;
    repeat (n) step();
  endtask

  // Holds the instruction already in cur_in[d] until it issues; freeze follows frz_mask per cycle.
  task automatic run_until_issue(input int d, input logic [15:0] frz_mask, output int stalls);
    logic issued;
    stalls = 0;
    issued = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cur_in[d].frz = frz_mask[c];
      @(negedge clk);
      if (o_stall[d]) stalls++;
      if (o_issue[d]) issued = 1'b1;
      step();
      if (issued) break;
    end
    cur_in[d] = '0;
    if (!issued) check("issue_timeout", 0, 1);
  endtask

  int s;

  initial begin
    cur_in[0] = '0;
    cur_in[1] = '0;
    for (int d = 0; d < 2; d++) begin
      m_n[d]  = 0;
      m_sc[d] = 0;
    end
    rst = 1'b1;
    #2;
    check("rst_stall", o_stall[0], 0);
    check("rst_issue", o_issue[0], 0);
    check("rst_full", o_full[1], 0);
    check("rst_pend", o_pend[1], 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // LOAD_LAT=1: load x5 then add x5+x6
    cur_in[0] = mk(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    @(negedge clk);
    check("ld5_issue", o_issue[0], 1);
    step();
    check("ld5_pend1", o_pend[0], 1);
    cur_in[0] = mk(1, 5'd5, 1, 5'd6, 1, 5'd10, 1, 0);
    run_until_issue(0, 16'h0000, s);
    check("lat1_stalls", s, 1);
    check("lat1_pend0", o_pend[0], 0);
    idle(2);

    // LOAD_LAT=3: load x7 then use
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd7, 1, 5'd0, 0, 5'd12, 1, 0);
    run_until_issue(1, 16'h0000, s);
    check("lat3_stalls", s, 3);

    // same with freeze held for two cycles mid-wait
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd7, 1, 5'd0, 0, 5'd12, 1, 0);
    run_until_issue(1, 16'h0006, s);
    check("frz_stalls", s, 5);
    idle(2);

    // fill both entries, third load waits for x1 to retire
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
    check("full_set", o_full[1], 1);
    run_until_issue(1, 16'h0000, s);
    check("full_stalls", s, 2);
    check("full_pend", o_pend[1], 1);
    idle(4);

    // x0 never pends; unused rs2 never hits
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    step();
    check("x0_pend", o_pend[1], 0);
    cur_in[1] = mk(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0);
    @(negedge clk);
    check("x0_stall", o_stall[1], 0);
    check("x0_issue", o_issue[1], 1);
    step();
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd2, 1, 5'd4, 0, 5'd0, 0, 0);
    @(negedge clk);
    check("st_stall", o_stall[1], 0);
    step();
    idle(4);

    // flush pulse while dependent of x9 sits in ID
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd9, 1, 5'd0, 0, 5'd13, 1, 0);
    cur_in[1].fl = 1'b1;
    @(negedge clk);
    check("fl_stall", o_stall[1], 0);
    check("fl_issue", o_issue[1], 0);
    step();
    cur_in[1].fl = 1'b0;
    run_until_issue(1, 16'h0000, s);
    check("fl_stalls", s, 2);
    check("fl_pend", o_pend[1], 0);
    idle(2);
`ifdef HAZARD_STATS_EN
    check("scnt_lat1", o_scnt[0], 1);
    check("scnt_lat3", o_scnt[1], 10);
`endif

    // async reset with two live entries
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
    step();
    cur_in[1] = mk(1, 5'd1, 1, 5'd0, 0, 5'd14, 1, 0);
    #2;
    check("pre_rst_stall", o_stall[1], 1);
    check("pre_rst_pend", o_pend[1], 2);
    rst = 1'b1;
    #1;
    check("arst_stall", o_stall[1], 0);
    check("arst_full", o_full[1], 0);
    check("arst_pend", o_pend[1], 0);
`ifdef HAZARD_STATS_EN
    check("arst_scnt", o_scnt[1], 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use and multi-cycle hazard unit for the ID stage of the 5-stage pipeline.
- Replaces the single-cycle compare against the ID/EX destination with a small scoreboard of pending load destinations, each with a latency countdown.
- Supports memories and caches whose load latency exceeds one cycle, and freezes its countdowns while the whole pipeline is held.
- Drives the PC/IF_ID hold and the ID/EX bubble insertion.

Parameters:
- ADDR_W, 5: register address width.
- NUM_ENTRIES, 2: scoreboard depth, meaning the maximum number of loads in flight; range 1..8.
- LOAD_LAT, 1: number of cycles a load destination stays pending after issue; range 1..15.
- CNT_W, 4: countdown width; must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- id_valid_i, in, 1: ID stage holds a real instruction.
- id_rs1_addr_i, in, ADDR_W: ID source register 1.
- id_rs2_addr_i, in, ADDR_W: ID source register 2.
- id_rs1_used_i, in, 1: rs1 is actually read.
- id_rs2_used_i, in, 1: rs2 is actually read.
- id_rd_addr_i, in, ADDR_W: ID destination register.
- id_rd_wr_i, in, 1: ID instruction writes rd.
- id_load_i, in, 1: ID instruction is a load.
- freeze_i, in, 1: global pipeline hold (e.g. memory wait); stops all state.
- flush_i, in, 1: ID instruction squashed (branch taken).
- stall_o, out, 1: hold PC and IF/ID; insert bubble into ID/EX.
- issue_o, out, 1: ID instruction advances to EX this cycle.
- full_o, out, 1: all entries valid.
- pending_cnt_o, out, ceil(log2(NUM_ENTRIES+1)): number of valid entries.

Behaviour:
- Reset: all entries invalid, countdowns 0. Outputs stall_o=0, issue_o=0, full_o=0, pending_cnt_o=0.
- Entry contents: valid bit, rd (ADDR_W), cnt (CNT_W).
- RAW hit: id_rsN_used_i=1, id_rsN_addr_i!=0, and the address equals the rd of any valid entry.
- WAW hit: id_rd_wr_i=1, id_rd_addr_i!=0, and the address equals the rd of any valid entry.
- Register x0 never hits.
- stall_o = id_valid_i & !flush_i & (RAW hit | WAW hit | (id_load_i & full_o & no entry with matching rd)). It is combinational from the current entry state and is independent of freeze_i.
- issue_o = id_valid_i & !flush_i & !stall_o & !freeze_i.
- Allocation (clock edge):
  - Triggers when issue_o, id_load_i, id_rd_wr_i are all 1 and rd!=0.
  - Takes the lowest-index invalid entry; it becomes valid with cnt=LOAD_LAT.
  - An entry retiring in the same cycle counts as occupied and is not reused that edge.
- Countdown (clock edge, only when freeze_i=0):
  - Each valid entry with cnt>1 decrements.
  - An entry with cnt==1 becomes invalid (retires).
  - With freeze_i=1, no entry changes and nothing is allocated.
- Latency: a load issued at edge T keeps its rd pending for cycles T..T+LOAD_LAT. A dependent instruction first issues at the edge ending cycle T+LOAD_LAT.
  - With LOAD_LAT=1 this is exactly one bubble, i.e. the classic load-use stall.
- Simultaneous retire and hazard: the hazard is evaluated on the pre-edge state. A dependent instruction stalls in the retiring cycle and issues in the following one.
- Because of the WAW-hit rule, a second load to an already-pending rd stalls until the first retires. No duplicate rd ever exists in the table.
- flush_i=1 suppresses stall_o, issue_o and allocation. Pending entries belong to older instructions, keep counting, and are never cleared by a flush.
- full_o and pending_cnt_o are registered: they are updated on the same edge as the entries and reflect post-edge state.
- Asynchronous reset mid-operation drops all entries immediately. stall_o falls in the same cycle.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds the output stall_cnt_o, out, 32.
  - Increments on every edge where stall_o=1 and freeze_i=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst_i.
- When undefined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
- LOAD_LAT=1: load x5 issues, next instruction adds x5+x6 → stall_o=1 for exactly 1 cycle, then issue_o=1; pending_cnt_o goes 0→1→0.
- LOAD_LAT=3: load x7, then a dependent use of x7 → 3 stall cycles. freeze_i held 2 cycles mid-wait → 5 stall cycles total and cnt stays unchanged while frozen.
- NUM_ENTRIES=2: loads to x1, x2 back-to-back (LOAD_LAT=3), third load to x3 → full_o=1 and the third load stalls until the x1 entry retires, then allocates entry 0.
- Load x0, then use of x0 → no allocation, stall_o never asserts. Load x4, then store reading x4 with rs2_used=0 → no stall.
- Pending x9 with a flush_i=1 pulse while a dependent sits in ID → stall_o=0 and issue_o=0 in that cycle; entry still retires on schedule.
- Assert rst_i asynchronously with 2 valid entries → stall_o=0, full_o=0, pending_cnt_o=0 before the next edge. With HAZARD_STATS_EN, stall_cnt_o equals the stall-cycle total across all of the above.
